// File: rtl/pci_target.sv
// ============================================================================
// pci_target -- responder end of the PCI-style shared bus.
//
// Decodes the address phase, claims frames whose word address falls inside
// BASE_ADDR .. BASE_ADDR+DEPTH-1, and then either serves a read burst from a
// local word memory or absorbs a write burst into it. All bus controls are
// active-low. A transfer happens on every rising edge where both iready and
// tready are low while the target is in its data state.
//
// Optional feature macro: PCI_TARGET_WAIT_EN
//   When defined, one WAIT cycle (deviceSelect low, tready high, bus Z) is
//   inserted before the data state: after the address phase for writes and
//   after the turnaround cycle for reads. Initiator signals are ignored there.
//
// Parameters:
//   BASE_ADDR  first word address claimed
//   DEPTH      number of 32-bit memory words
//   IW         index width, 2**IW >= DEPTH
//
// Ports:
//   clk           bus clock, everything samples on the rising edge
//   reset         asynchronous active-low reset
//   iframe        initiator frame (low = frame active, high in a data phase
//                 marks the final transfer)
//   iready        initiator ready (active-low)
//   cbe           command sampled in the address phase: 1 = read, 0 = write
//   addressdata   multiplexed address/data bus, driven only in read data
//   tready        target ready (active-low, registered)
//   deviceSelect  claim indicator (active-low, registered)
//
// Memory contents are not affected by reset.
// ============================================================================
module pci_target #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 10,
  parameter int          IW        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iframe,
  input  logic        iready,
  input  logic        cbe,
  inout  tri   [31:0] addressdata,
  output logic        tready,
  output logic        deviceSelect
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MISS,
    S_TURN,
`ifdef PCI_TARGET_WAIT_EN
    S_WAIT,
`endif
    S_DATA,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic          r_is_read;
  logic          r_tready;
  logic          r_devsel;
  logic          r_drive;
  logic [31:0]   r_rdata;
  logic [31:0]   r_mem [DEPTH];

  logic [31:0]   w_off;
  logic          w_hit;
  logic          w_xfer;
  logic [IW-1:0] w_idx_inc;
  logic          w_wr_en;
  logic          w_rd_en;
  logic [IW-1:0] w_rd_addr;
  logic          w_enter_data;

  // Unsigned offset from the window base; an address below BASE_ADDR is
  // rejected explicitly so the subtraction cannot wrap into a false hit.
  assign w_off = addressdata - BASE_ADDR;
  assign w_hit = (addressdata >= BASE_ADDR) && (w_off < 32'(DEPTH));

  assign w_xfer    = (r_state == S_DATA) && !iready && !r_tready;
  assign w_idx_inc = (r_idx == IW'(DEPTH - 1)) ? '0 : r_idx + 1'b1;

  // Last cycle before a read burst's data state: the first word must be
  // fetched here so it is on the bus right after the edge.
`ifdef PCI_TARGET_WAIT_EN
  assign w_enter_data = (r_state == S_WAIT);
`else
  assign w_enter_data = (r_state == S_TURN);
`endif

  assign w_wr_en = w_xfer && !r_is_read;
  assign w_rd_en = r_is_read && (w_enter_data || w_xfer);
  // During a transfer the word after the current one is prefetched so the
  // bus presents it one cycle later, giving one word per clock.
  assign w_rd_addr = w_xfer ? w_idx_inc : r_idx;

  // Word memory with registered read; no reset so it maps onto block RAM
  // and keeps its contents across a bus reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_idx] <= addressdata;
    end
    if (w_rd_en) begin
      r_rdata <= r_mem[w_rd_addr];
    end
  end

  // Bus control state machine with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_is_read <= 1'b0;
      r_tready  <= 1'b1;
      r_devsel  <= 1'b1;
      r_drive   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!iframe) begin
            r_is_read <= cbe;
            if (w_hit) begin
              r_idx    <= w_off[IW-1:0];
              r_devsel <= 1'b0;
              if (cbe) begin
                r_state <= S_TURN;
              end else begin
`ifdef PCI_TARGET_WAIT_EN
                r_state  <= S_WAIT;
`else
                r_state  <= S_DATA;
                r_tready <= 1'b0;
`endif
              end
            end else begin
              r_state <= S_MISS;
            end
          end
        end

        // Sit out the rest of a frame that is not ours so its data phases
        // are never mistaken for a new address phase.
        S_MISS: begin
          if (iframe) begin
            r_state <= S_IDLE;
          end
        end

        // Read turnaround: initiator releases the bus, target does not drive.
        S_TURN: begin
`ifdef PCI_TARGET_WAIT_EN
          r_state  <= S_WAIT;
`else
          r_state  <= S_DATA;
          r_tready <= 1'b0;
          r_drive  <= 1'b1;
`endif
        end

`ifdef PCI_TARGET_WAIT_EN
        S_WAIT: begin
          r_state  <= S_DATA;
          r_tready <= 1'b0;
          r_drive  <= r_is_read;
        end
`endif

        S_DATA: begin
          if (w_xfer) begin
            r_idx <= w_idx_inc;
            if (iframe) begin
              r_state  <= S_DONE;
              r_devsel <= 1'b1;
              r_tready <= 1'b1;
              r_drive  <= 1'b0;
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state  <= S_IDLE;
          r_tready <= 1'b1;
          r_devsel <= 1'b1;
          r_drive  <= 1'b0;
        end
      endcase
    end
  end

  assign tready       = r_tready;
  assign deviceSelect = r_devsel;
  assign addressdata  = r_drive ? r_rdata : 32'bz;

endmodule
